// File: rtl/fwd_pkg.sv
// Shared types and helpers for the execute-stage forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int MAX_REG_AW = 8;
  localparam logic [MAX_REG_AW-1:0] ZERO_REG = 8'd0;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic                  is_load;
    logic [MAX_REG_AW-1:0] rd;
  } fwd_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  // A load result only exists on the stage buses from index load_lat onward.
  function automatic logic stage_ready(input logic is_load, input int k, input int load_lat);
    stage_ready = ~is_load | (k >= load_lat);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-first producer search for one execute source operand.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int REG_AW    = 5,
  parameter int SW        = 1
) (
  input  fwd_entry_t [FWD_DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]          src,
  input  logic                       used,
  output logic                       hit,
  output logic                       ready,
  output logic [SW-1:0]              stage
);

  logic [MAX_REG_AW-1:0] src_ext_s;
  logic [FWD_DEPTH-1:0]  match_s;
  logic                  found_s;
  logic                  sel_ready_s;

  assign src_ext_s = MAX_REG_AW'(src);

  // Per-stage match vector; register 0 is never a producer.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      match_s[k] = used & entries[k].valid & entries[k].wen &
                   (entries[k].rd == src_ext_s) & (src_ext_s != ZERO_REG);
    end
  end

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    found_s     = 1'b0;
    sel_ready_s = 1'b0;
    stage       = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      found_s     = found_s | match_s[k];
      stage       = match_s[k] ? SW'(k) : stage;
      sel_ready_s = match_s[k] ? stage_ready(entries[k].is_load, k, LOAD_LAT) : sel_ready_s;
    end
    hit   = found_s;
    ready = found_s & sel_ready_s;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Execute-stage operand forwarding and load-use stall unit with a shadow tag pipeline.
// Optional stall statistics counters are enabled by defining FWD_STALL_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  localparam int SW       = (FWD_DEPTH > 1) ? $clog2(FWD_DEPTH) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        ex_valid,
  input  logic                        ex_wen,
  input  logic                        ex_is_load,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
  input  logic [NUM_SRC-1:0]          ex_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
  output logic [NUM_SRC*DATA_W-1:0]   ex_operand,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic [NUM_SRC*SW-1:0]       fwd_stage,
`ifdef FWD_STALL_STATS_EN
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 stall_events,
`endif
  output logic                        stall
);

  fwd_entry_t [FWD_DEPTH-1:0] shadow_r;
  fwd_entry_t [FWD_DEPTH-1:0] shadow_nxt_s;
  logic [NUM_SRC-1:0]         hit_s;
  logic [NUM_SRC-1:0]         ready_s;
  logic [NUM_SRC*SW-1:0]      stage_s;

  // Next shadow contents: a stalled instruction enters as a bubble, flush clears everything.
  always_comb begin
    shadow_nxt_s[0].valid   = ex_valid & ~stall & ~flush;
    shadow_nxt_s[0].wen     = ex_wen;
    shadow_nxt_s[0].is_load = ex_is_load;
    shadow_nxt_s[0].rd      = MAX_REG_AW'(ex_rd);
    for (int k = 1; k < FWD_DEPTH; k++) begin
      shadow_nxt_s[k]       = shadow_r[k-1];
      shadow_nxt_s[k].valid = shadow_r[k-1].valid & ~flush;
    end
  end

  // Shadow tag pipeline register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r <= '0;
    end else begin
      shadow_r <= shadow_nxt_s;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .REG_AW    (REG_AW),
      .SW        (SW)
    ) u_match (
      .entries (shadow_r),
      .src     (ex_src[s*REG_AW +: REG_AW]),
      .used    (ex_src_used[s]),
      .hit     (hit_s[s]),
      .ready   (ready_s[s]),
      .stage   (stage_s[s*SW +: SW])
    );
  end

  assign fwd_hit = hit_s & ready_s;
  assign stall   = ex_valid & (|(hit_s & ~ready_s));

  // Operand muxes; a blocked source still presents register-file data.
  always_comb begin
    ex_operand = rf_data;
    fwd_stage  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_stage[s*SW +: SW] = fwd_hit[s] ? stage_s[s*SW +: SW] : '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        ex_operand[s*DATA_W +: DATA_W] = (fwd_hit[s] && (stage_s[s*SW +: SW] == SW'(k)))
                                         ? stage_data[k*DATA_W +: DATA_W]
                                         : ex_operand[s*DATA_W +: DATA_W];
      end
    end
  end

`ifdef FWD_STALL_STATS_EN
  stall_state_e state_r;
  stall_state_e state_nxt_s;

  // RUN/STALL state register used to spot stall rising edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state simply tracks the current stall level.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN:   state_nxt_s = stall ? ST_STALL : ST_RUN;
      ST_STALL: state_nxt_s = stall ? ST_STALL : ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // Saturating statistics; only reset_n clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
      stall_events <= 32'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (stall && (state_r == ST_RUN) && (stall_events != 32'hFFFF_FFFF)) begin
        stall_events <= stall_events + 32'd1;
      end else begin
        stall_events <= stall_events;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random traffic against a history model.
module tb_fwd_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int FD = 2;
  localparam int LL = 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          ex_valid;
  logic          ex_wen;
  logic          ex_is_load;
  logic [AW-1:0] ex_rd;
  logic [NS*AW-1:0] ex_src;
  logic [NS-1:0] ex_src_used;
  logic [NS*DW-1:0] rf_data;
  logic [FD*DW-1:0] stage_data;
  logic [NS*DW-1:0] ex_operand;
  logic [NS-1:0] fwd_hit;
  logic [NS-1:0] fwd_stage;
  logic          stall;
`ifdef FWD_STALL_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   stall_events;
`endif

  int checks = 0;
  int failures = 0;

  // History of instructions that left execute: index 0 = one cycle ago.
  int m_v[FD];
  int m_w[FD];
  int m_l[FD];
  int m_rd[FD];
  logic exp_stall;
  logic p_v, p_w, p_l, p_fl;
  logic [AW-1:0] p_rd;

  fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_wen      (ex_wen),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_src      (ex_src),
    .ex_src_used (ex_src_used),
    .rf_data     (rf_data),
    .stage_data  (stage_data),
    .ex_operand  (ex_operand),
    .fwd_hit     (fwd_hit),
    .fwd_stage   (fwd_stage),
`ifdef FWD_STALL_STATS_EN
    .stall_cycles(stall_cycles),
    .stall_events(stall_events),
`endif
    .stall       (stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < FD; k++) begin
      m_v[k] = 0; m_w[k] = 0; m_l[k] = 0; m_rd[k] = 0;
    end
  endtask

  // Drive one execute instruction, then compare all outputs with the history model.
  task automatic drive_check(input logic v, input logic w, input logic l, input logic [AW-1:0] rd,
                             input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                             input logic [1:0] used, input logic fl);
    logic       any_block;
    logic [1:0] e_hit;
    logic [1:0] e_stage;
    logic [63:0] e_op;
    int src;
    int found;
    ex_valid = v; ex_wen = w; ex_is_load = l; ex_rd = rd;
    ex_src = {s1, s0}; ex_src_used = used; flush = fl;
    rf_data = {$urandom, $urandom};
    stage_data = {$urandom, $urandom};
    p_v = v; p_w = w; p_l = l; p_rd = rd; p_fl = fl;
    #1;
    any_block = 1'b0; e_hit = 2'b00; e_stage = 2'b00; e_op = rf_data;
    for (int s = 0; s < NS; s++) begin
      src = (s == 0) ? int'(s0) : int'(s1);
      found = -1;
      if (used[s] && src != 0) begin
        for (int k = FD - 1; k >= 0; k--) begin
          if (m_v[k] != 0 && m_w[k] != 0 && m_rd[k] == src) found = k;
        end
      end
      if (found >= 0) begin
        if (m_l[found] != 0 && found < LL) begin
          any_block = 1'b1;
        end else begin
          e_hit[s] = 1'b1;
          e_stage[s] = found[0];
          e_op[s*DW +: DW] = stage_data[found*DW +: DW];
        end
      end
    end
    exp_stall = v & any_block;
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("fwd_stage", 64'(fwd_stage), 64'(e_stage));
    chk("ex_operand", ex_operand, e_op);
  endtask

  // Clock edge: the model records what left execute this cycle.
  task automatic advance();
    @(posedge clock);
    if (p_fl) begin
      model_clear();
    end else begin
      for (int k = FD - 1; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_l[k] = m_l[k-1]; m_rd[k] = m_rd[k-1];
      end
      m_v[0] = (p_v && !exp_stall) ? 1 : 0;
      m_w[0] = int'(p_w); m_l[0] = int'(p_l); m_rd[0] = int'(p_rd);
    end
    @(negedge clock);
  endtask

  task automatic cyc(input logic v, input logic w, input logic l, input logic [AW-1:0] rd,
                     input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                     input logic [1:0] used, input logic fl);
    drive_check(v, w, l, rd, s0, s1, used, fl);
    advance();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_rd = '0; ex_src = '0; ex_src_used = '0;
    rf_data = 64'h1111_2222_3333_4444; stage_data = 64'h5555_6666_7777_8888;
    model_clear();
    exp_stall = 1'b0;
    @(negedge clock); @(negedge clock);
    ex_valid = 1'b1; ex_src = {5'd3, 5'd3}; ex_src_used = 2'b11; #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_stage", 64'(fwd_stage), 64'd0);
    chk("rst_operand", ex_operand, rf_data);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: ALU back-to-back
    cyc(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b11, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b0);
    chk("t1_hit0", 64'(fwd_hit[0]), 64'd1);
    chk("t1_op0", 64'(ex_operand[31:0]), 64'(stage_data[31:0]));
    chk("t1_stall", 64'(stall), 64'd0);
    advance();

    // 2: load-use stalls one cycle, then forwards from stage 1
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 2'b01, 1'b0);
    chk("t2_stall", 64'(stall), 64'd1);
    advance();
    drive_check(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 2'b01, 1'b0);
    chk("t2_stall_clr", 64'(stall), 64'd0);
    chk("t2_stage0", 64'(fwd_stage[0]), 64'd1);
    chk("t2_op0", 64'(ex_operand[31:0]), 64'(stage_data[63:32]));
    advance();

    // 3: r0 writer is never forwarded
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);
    chk("t3_hit", 64'(fwd_hit), 64'd0);
    chk("t3_op", ex_operand, rf_data);
    advance();

    // 4: two writers of r7, youngest wins; a young load blocks the older ALU result
    cyc(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b0);
    chk("t4_stage0", 64'(fwd_stage[0]), 64'd0);
    chk("t4_hit0", 64'(fwd_hit[0]), 64'd1);
    advance();
    cyc(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0);
    chk("t4_load_stall", 64'(stall), 64'd1);
    chk("t4_load_hit", 64'(fwd_hit), 64'd0);
    advance();

    // 5: flush during a load-use stall, then an unused matching source
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b11, 1'b1);
    chk("t5_stall_flush", 64'(stall), 64'd1);
    advance();
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b11, 1'b0);
    chk("t5_after_stall", 64'(stall), 64'd0);
    chk("t5_after_hit", 64'(fwd_hit), 64'd0);
    advance();
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0);
    chk("t5_unused", 64'(stall), 64'd0);
    advance();

    // 6: asynchronous reset in the middle of a stall
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    drive_check(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
    chk("t6_pre", 64'(stall), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_stall", 64'(stall), 64'd0);
    chk("t6_async_op", ex_operand, rf_data);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;

`ifdef FWD_STALL_STATS_EN
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
    end
    chk("stats_cycles", 64'(stall_cycles), 64'd3);
    chk("stats_events", 64'(stall_events), 64'd3);
`endif

    // Random traffic with a small register range to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
